uart2_rx: RTL
=============

# uart2_rx

Serial receiver that sits directly downstream of the UART2 transmitter. It samples the serial line driven by the transmitter's `tx2` output and recovers each frame: start bit (0), 8 data bits LSB first, even parity bit (XOR of the data byte), stop bit (1). Each recovered byte is presented to the system side through a one-entry valid/ready holding register, together with parity, framing and overrun status.

## Interface
- `CLKS_PER_BIT`, default 16: `clk_sis` cycles per serial bit; legal values are ≥ 4.
- `clk_sis`  in  1  system clock; the only clock in the block.
- `rst`  in  1  asynchronous, active-high reset.
- `rx2`  in  1  serial input, asynchronous to `clk_sis`; connects to the transmitter's `tx2`; idles high.
- `data_out`  out  8  received byte; reset 8'h00.
- `data_valid`  out  1  `data_out` and the error flags hold an unconsumed byte; reset 0.
- `data_ready`  in  1  consumer accepts the byte on any cycle where `data_valid && data_ready`.
- `parity_err`  out  1  the held byte failed the even-parity check; qualified by `data_valid`; reset 0.
- `frame_err`  out  1  the held byte's stop bit sampled 0; qualified by `data_valid`; reset 0.
- `overrun`  out  1  one-cycle pulse when a completed byte is dropped; reset 0.
- `busy`  out  1  FSM is not in IDLE; reset 0.

## Operation
- `rx2` passes through a 2-FF synchronizer (reset value 1) into `rx_s`. A falling edge is detected as `rx_s` previous = 1 and current = 0.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- IDLE: on a falling edge, go to START and load the bit counter with `CLKS_PER_BIT/2 - 1`.
- START: at count 0, sample `rx_s`. If 0, go to DATA with the counter at `CLKS_PER_BIT - 1` and the bit index at 0. If 1, it is a false start: go back to IDLE with no output.
- DATA: at count 0, shift the sampled bit into the MSB of the shift register (shift right), so bit 0 ends up as the first bit received. After index 7 is sampled, go to PARITY. Otherwise increment the index and reload the counter.
- PARITY: at count 0, capture the parity bit and go to STOP.
- STOP: at count 0, sample the stop bit and return to IDLE.
  - Compute `perr = ^shift ^ parity_sample` and `ferr = ~stop_sample`.
  - If the holding register is free (or is being consumed this same cycle), load `data_out`, `parity_err` and `frame_err`.
  - Otherwise drop the new byte, keep the old one, and pulse `overrun`.
- A byte with a framing error is still delivered, with `frame_err = 1`.
- Handshake: `data_valid` stays high until `data_valid && data_ready`, then clears on the next edge unless a new byte is loaded on that same edge. `data_out` is stable while `data_valid` is high.
- The bit counter is `$clog2(CLKS_PER_BIT)` bits wide and counts down. The bit index is 3 bits.

## Timing
- The start edge is seen 2–3 cycles after `rx2` falls (synchronizer delay).
- Samples are taken at bit centre ± 1 cycle.
- `data_valid` rises 1 cycle after the stop-bit sample.
- The next frame's start edge is accepted on the cycle the FSM re-enters IDLE; back-to-back frames need no idle gap beyond the stop bit.
- Simultaneous load and consume on the same edge: load wins, `data_valid` stays 1, and there is no overrun.
- Reset mid-frame: the FSM goes to IDLE, all outputs take their reset values, the synchronizer is forced to 1, and the partial byte is discarded.
- A line held low (break) gives one frame of 0x00 with `frame_err = 1`. No new frame starts until the line goes high and then falls again.

## Structure
- `uart_pkg` holds:
  - the state encodings (IDLE=3'b000, START=3'b001, DATA=3'b010, PARITY=3'b011, STOP=3'b100, matching the transmitter);
  - `UART_DATA_BITS = 8`;
  - the even-parity convention.
- Sub-module `uart_sync`: 2-FF synchronizer plus falling-edge detector, with a reset value parameter. It is reusable on other asynchronous inputs.

## Test plan
- Reset, then `rx2` idle high → all outputs at reset values, `busy = 0`, no `data_valid` for 1000 cycles.
- Frame 0xA5 with parity 0 and stop 1, `data_ready` held 0 → `data_out = 8'hA5`, `data_valid = 1`, `parity_err = 0`, `frame_err = 0`. Then `data_ready` pulsed for 1 cycle → `data_valid = 0` on the next edge.
- Frame 0x07 with parity 0 (wrong) → `data_out = 8'h07`, `parity_err = 1`. Next, frame 0x00 with stop bit 0 → `data_out = 8'h00`, `frame_err = 1`.
- Glitch: `rx2` low for `CLKS_PER_BIT/4` cycles → false start, FSM back in IDLE, no `data_valid`.
- Two back-to-back frames 0x3C then 0xC3 with `data_ready = 0` → `data_out` stays 0x3C and `overrun` pulses once at the second stop sample. Repeating with `data_ready = 1` → both bytes delivered in order and no `overrun`.
- Assert `rst` during DATA of frame 0x5A, release it, then send 0x81 → 0x5A is never output and `data_out = 8'h81` with no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART2 link: FSM state encodings, frame width
// and the parity convention used by both transmitter and receiver.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    // Even parity: the parity bit equals the XOR of the data bits.
    localparam logic UART_PARITY_ODD = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_START  = 3'b001,
        ST_DATA   = 3'b010,
        ST_PARITY = 3'b011,
        ST_STOP   = 3'b100
    } uart_state_e;

    function automatic logic parity_mismatch(
        input logic [UART_DATA_BITS-1:0] data,
        input logic                      parity_bit
    );
        return (^data) ^ parity_bit ^ UART_PARITY_ODD;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous input, plus a falling-edge
// detector on the synchronized value.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_sis,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk_sis or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q;
    assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart2_rx.sv
// UART2 receiver: recovers start/8 data/even parity/stop frames from rx2 and
// presents each byte through a one-entry valid/ready holding register.
module uart2_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                      clk_sis,
    input  logic                      rst,
    input  logic                      rx2,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic                      parity_err,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_IDX  = 3'(UART_DATA_BITS - 1);

    logic rx_s, rx_fall;

    uart_sync #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk_sis (clk_sis),
        .rst     (rst),
        .din     (rx2),
        .dout    (rx_s),
        .fall    (rx_fall)
    );

    uart_state_e               state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      par_q, par_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      perr_q, perr_d;
    logic                      ferr_q, ferr_d;
    logic                      ovr_q, ovr_d;
    logic                      busy_q, busy_d;
    logic                      tick;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;
        tick    = (cnt_q == '0);

        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        if (state_q != ST_IDLE && !tick) begin
            cnt_d = cnt_q - CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_fall) begin
                    state_d = ST_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        cnt_d   = BIT_LOAD;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                    cnt_d   = BIT_LOAD;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_PARITY;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    par_d   = rx_s;
                    cnt_d   = BIT_LOAD;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    // A consume on this same edge frees the slot, so the new byte wins.
                    if (!valid_q || data_ready) begin
                        data_d  = shift_q;
                        perr_d  = parity_mismatch(shift_q, par_q);
                        ferr_d  = ~rx_s;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_sis or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule
